// File: rtl/barrett_param_gen_64b_if.sv
// Control/result bundle for the Barrett constant generator.
// The master drives the request side; the slave (the generator) returns K, U and status.
interface barrett_param_gen_64b_if;
    logic          iEn;
    logic          iClr;
    logic          iStart;
    logic [63:0]   iMod;
    logic          oBusy;
    logic          oValid;
    logic          oErr;
    logic [6:0]    oK;
    logic [127:0]  oU;

    modport master (
        output iEn, iClr, iStart, iMod,
        input  oBusy, oValid, oErr, oK, oU
    );

    modport slave (
        input  iEn, iClr, iStart, iMod,
        output oBusy, oValid, oErr, oK, oU
    );
endinterface

// File: rtl/barrett_param_gen_64b.sv
// Barrett constant generator: K = bit length of the modulus, U = floor(2^(2K) / modulus),
// produced by a fixed-latency restoring divider retiring one quotient bit per enabled cycle.
module barrett_param_gen_64b #(
    parameter int DW = 64,
    parameter int QW = 129
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    barrett_param_gen_64b_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC_K = 2'd1,
        ST_DIV    = 2'd2
    } state_t;

    // Bit length of a value: 0 for zero, otherwise MSB index + 1.
    function automatic logic [6:0] bit_len(input logic [DW-1:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int b = 0; b < DW; b++) begin
            if (v[b]) begin
                n = 7'(b + 1);
            end
        end
        return n;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   mod_r;
    logic [DW-1:0]   rem_r;
    logic [QW-3:0]   quo_r;
    logic [6:0]      k_r;
    logic [7:0]      cnt_r;
    logic            busy_r;
    logic            valid_r;
    logic            err_r;
    logic [6:0]      k_out_r;
    logic [QW-2:0]   u_r;

    logic            accept_s;
    logic            mod_zero_s;
    logic [6:0]      k_calc_s;
    logic            d_s;
    logic [DW:0]     shifted_s;
    logic            ge_s;
    logic [DW-1:0]   diff_s;
    logic [DW-1:0]   rem_nxt_s;
    logic [QW-2:0]   quo_final_s;

    // Next-state logic; a start is only taken once the previous result pulse has retired.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.iStart && !valid_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_CALC_K;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC_K: begin
                if (mod_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One restoring-division step; the dividend 2^(2K) contributes a single 1 bit at i == 2K.
    // R < mod before the shift, so a successful subtraction always fits back into DW bits.
    always_comb begin
        mod_zero_s  = (mod_r == {DW{1'b0}});
        k_calc_s    = bit_len(mod_r);
        d_s         = (cnt_r == {k_r, 1'b0});
        shifted_s   = {rem_r, d_s};
        ge_s        = (shifted_s >= {1'b0, mod_r});
        diff_s      = shifted_s[DW-1:0] - mod_r;
        rem_nxt_s   = ge_s ? diff_s : shifted_s[DW-1:0];
        quo_final_s = {quo_r, ge_s};
    end

    // State, datapath and registered outputs; iEn low freezes everything, iClr acts like reset.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_r <= ST_IDLE;
            mod_r   <= {DW{1'b0}};
            rem_r   <= {DW{1'b0}};
            quo_r   <= {(QW-2){1'b0}};
            k_r     <= 7'd0;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            k_out_r <= 7'd0;
            u_r     <= {(QW-1){1'b0}};
        end else if (bus.iClr) begin
            state_r <= ST_IDLE;
            mod_r   <= {DW{1'b0}};
            rem_r   <= {DW{1'b0}};
            quo_r   <= {(QW-2){1'b0}};
            k_r     <= 7'd0;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            k_out_r <= 7'd0;
            u_r     <= {(QW-1){1'b0}};
        end else if (bus.iEn) begin
            state_r <= state_nxt_s;
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mod_r  <= bus.iMod;
                        rem_r  <= {DW{1'b0}};
                        quo_r  <= {(QW-2){1'b0}};
                        busy_r <= 1'b1;
                        err_r  <= 1'b0;
                    end
                end
                ST_CALC_K: begin
                    if (mod_zero_s) begin
                        err_r   <= 1'b1;
                        k_out_r <= 7'd0;
                        u_r     <= {(QW-1){1'b0}};
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        k_r   <= k_calc_s;
                        cnt_r <= 8'(QW - 1);
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_final_s[QW-3:0];
                    cnt_r <= cnt_r - 8'd1;
                    if (cnt_r == 8'd0) begin
                        u_r     <= quo_final_s;
                        k_out_r <= k_r;
                        err_r   <= 1'b0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oBusy  = busy_r;
    assign bus.oValid = valid_r;
    assign bus.oErr   = err_r;
    assign bus.oK     = k_out_r;
    assign bus.oU     = u_r;

endmodule

// File: tb/tb_barrett_param_gen_64b.sv
// Scoreboard bench for barrett_param_gen_64b: expected K/U from floor(4^K/m) pushed at start,
// popped and compared when oValid rises; results are also exercised in a Barrett reduction.
module tb_barrett_param_gen_64b;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    barrett_param_gen_64b_if bus ();
    barrett_param_gen_64b dut (.iClk(clk), .iRstN(rst_n), .bus(bus));

    typedef struct {
        logic         err;
        logic [6:0]   k;
        logic [127:0] u;
        logic [63:0]  m;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic exp_t model(input logic [63:0] m);
        exp_t        e;
        logic [63:0] t;
        logic [128:0] num;
        e.m = m;
        e.k = 7'd0;
        t   = m;
        while (t != 64'd0) begin
            t   = t >> 1;
            e.k = e.k + 7'd1;
        end
        if (m == 64'd0) begin
            e.err = 1'b1;
            e.u   = 128'd0;
        end else begin
            e.err = 1'b0;
            num   = 129'd1 << (2 * int'(e.k));
            e.u   = 128'(num / {65'd0, m});
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [63:0] m, input bit push);
        if (bus.oValid) tick();
        bus.iMod   = m;
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        bus.iMod   = {$urandom, $urandom};
        if (push) sb.push_back(model(m));
    endtask

    task automatic wait_valid(input int budget, input bit rand_en,
                              output bit got, output int n_en, output bit busy_prev);
        bit en_s;
        got       = 1'b0;
        n_en      = 0;
        busy_prev = bus.oBusy;
        for (int c = 0; c < budget; c++) begin
            busy_prev = bus.oBusy;
            en_s      = bus.iEn;
            tick();
            if (en_s) n_en++;
            if (bus.oValid) begin
                got = 1'b1;
                break;
            end
            if (rand_en) begin
                bus.iEn    = 1'($urandom_range(0, 1));
                bus.iStart = 1'($urandom_range(0, 1));
                bus.iMod   = {$urandom, $urandom};
            end
        end
        bus.iStart = 1'b0;
        bus.iEn    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.iEn = 1'b1; bus.iClr = 1'b0; bus.iStart = 1'b0; bus.iMod = 64'd0;
        tick(); tick();
        n_vec++;
        if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0 || bus.oErr !== 1'b0 ||
            bus.oK !== 7'd0 || bus.oU !== 128'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b valid=%b err=%b k=%0d u=%h, want all 0",
                     bus.oBusy, bus.oValid, bus.oErr, bus.oK, bus.oU);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit got, bp; int n; exp_t e;
        start_run(64'd7, 1'b1);
        wait_valid(300, 1'b0, got, n, bp);
        n_vec++;
        if (!got || n != 130) begin
            n_err++;
            $display("FAIL basic_latency: got=%b cycles=%0d, want valid after 130", got, n);
        end
        n_vec++;
        if (bp !== 1'b1 || bus.oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: busy before=%b at valid=%b, want 1 then 0", bp, bus.oBusy);
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.oK !== e.k || bus.oU !== e.u || bus.oErr !== e.err || e.k !== 7'd3 || e.u !== 128'd9) begin
            n_err++;
            $display("FAIL basic_result: err=%b k=%0d u=%0d, want err=0 k=3 u=9", bus.oErr, bus.oK, bus.oU);
        end
        tick();
        n_vec++;
        if (bus.oValid !== 1'b0 || bus.oK !== 7'd3) begin
            n_err++;
            $display("FAIL basic_pulse: valid=%b k=%0d, want valid=0 k held 3", bus.oValid, bus.oK);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] fixed_m [4];
        logic [63:0] m, a, b;
        logic [255:0] x, q, r;
        bit got, bp; int n, subs; exp_t e;
        fixed_m[0] = 64'd12289;
        fixed_m[1] = 64'd1;
        fixed_m[2] = 64'h8000_0000_0000_0000;
        fixed_m[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 154; i++) begin
            if (i < 4) m = fixed_m[i];
            else       m = {$urandom, $urandom} >> $urandom_range(0, 63);
            start_run(m, 1'b1);
            wait_valid(300, 1'b0, got, n, bp);
            e = sb.pop_front();
            n_vec++;
            if (!got || bus.oK !== e.k || bus.oU !== e.u || bus.oErr !== e.err) begin
                n_err++;
                $display("FAIL vector m=%h: got=%b err=%b k=%0d u=%h, want err=%b k=%0d u=%h",
                         m, got, bus.oErr, bus.oK, bus.oU, e.err, e.k, e.u);
            end
            if (m != 64'd0) begin
                a = {$urandom, $urandom} % m;
                b = {$urandom, $urandom} % m;
                x = 256'(a) * 256'(b);
                q = ((x >> (int'(bus.oK) - 1)) * 256'(bus.oU)) >> (int'(bus.oK) + 1);
                r = x - q * 256'(m);
                subs = 0;
                while (r >= 256'(m) && subs < 3) begin
                    r = r - 256'(m);
                    subs++;
                end
                n_vec++;
                if (subs > 2 || r !== (x % 256'(m))) begin
                    n_err++;
                    $display("FAIL barrett m=%h a=%h b=%h: r=%h subs=%0d, want %h",
                             m, a, b, r, subs, x % 256'(m));
                end
            end
        end
    endtask

    task automatic test_zero();
        bit got, bp; int n; exp_t e;
        start_run(64'd0, 1'b1);
        wait_valid(300, 1'b0, got, n, bp);
        n_vec++;
        if (!got || n != 1) begin
            n_err++;
            $display("FAIL zero_latency: got=%b cycles=%0d, want 1", got, n);
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.oErr !== 1'b1 || bus.oK !== e.k || bus.oU !== e.u || e.k !== 7'd0) begin
            n_err++;
            $display("FAIL zero_result: err=%b k=%0d u=%h, want err=1 k=0 u=0", bus.oErr, bus.oK, bus.oU);
        end
        start_run(64'd5, 1'b1);
        wait_valid(300, 1'b0, got, n, bp);
        e = sb.pop_front();
        n_vec++;
        if (!got || bus.oErr !== 1'b0 || bus.oK !== e.k || bus.oU !== e.u || e.u !== 128'd12) begin
            n_err++;
            $display("FAIL zero_recover: err=%b k=%0d u=%0d, want err=0 k=3 u=12", bus.oErr, bus.oK, bus.oU);
        end
    endtask

    task automatic test_stall();
        bit got, bp; int n; exp_t e;
        start_run(64'd7, 1'b1);
        wait_valid(3000, 1'b1, got, n, bp);
        n_vec++;
        if (!got || n != 130) begin
            n_err++;
            $display("FAIL stall_latency: got=%b enabled cycles=%0d, want 130", got, n);
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.oK !== e.k || bus.oU !== e.u || bus.oErr !== e.err) begin
            n_err++;
            $display("FAIL stall_result: k=%0d u=%0d, want k=%0d u=%0d", bus.oK, bus.oU, e.k, e.u);
        end
    endtask

    task automatic test_abort();
        bit got, bp; int n; exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            start_run(64'd1000003, 1'b0);
            for (int c = 0; c < 51; c++) tick();
            if (pass == 0) begin
                bus.iClr = 1'b1;
                tick();
                bus.iClr = 1'b0;
            end else begin
                rst_n = 1'b0;
                #1;
            end
            n_vec++;
            if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0 || bus.oErr !== 1'b0 ||
                bus.oK !== 7'd0 || bus.oU !== 128'd0) begin
                n_err++;
                $display("FAIL abort%0d_clear: busy=%b valid=%b err=%b k=%0d u=%h, want all 0",
                         pass, bus.oBusy, bus.oValid, bus.oErr, bus.oK, bus.oU);
            end
            if (pass == 1) begin
                tick();
                rst_n = 1'b1;
            end
            wait_valid(200, 1'b0, got, n, bp);
            n_vec++;
            if (got) begin
                n_err++;
                $display("FAIL abort%0d_novalid: valid=%b after abort, want 0", pass, got);
            end
            start_run(64'd12289, 1'b1);
            wait_valid(300, 1'b0, got, n, bp);
            e = sb.pop_front();
            n_vec++;
            if (!got || bus.oK !== e.k || bus.oU !== e.u || e.u !== 128'd21843) begin
                n_err++;
                $display("FAIL abort%0d_restart: got=%b k=%0d u=%0d, want k=14 u=21843",
                         pass, got, bus.oK, bus.oU);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got, bp; int n; exp_t e;
        start_run(64'd9, 1'b1);
        wait_valid(300, 1'b0, got, n, bp);
        e = sb.pop_front();
        n_vec++;
        if (!got || bus.oK !== e.k || bus.oU !== e.u) begin
            n_err++;
            $display("FAIL b2b_first: k=%0d u=%0d, want k=%0d u=%0d", bus.oK, bus.oU, e.k, e.u);
        end
        bus.iMod   = 64'd3;
        bus.iStart = 1'b1;
        tick();
        n_vec++;
        if (bus.oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ignored: busy=%b during valid-cycle start, want 0", bus.oBusy);
        end
        tick();
        bus.iStart = 1'b0;
        sb.push_back(model(64'd3));
        n_vec++;
        if (bus.oBusy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b after next cycle, want 1", bus.oBusy);
        end
        wait_valid(300, 1'b0, got, n, bp);
        e = sb.pop_front();
        n_vec++;
        if (!got || n != 130 || bus.oK !== e.k || bus.oU !== e.u || e.u !== 128'd5) begin
            n_err++;
            $display("FAIL b2b_second: got=%b cycles=%0d k=%0d u=%0d, want 130 k=2 u=5",
                     got, n, bus.oK, bus.oU);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_zero();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
